// File: rtl/wbm_arb2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the DDR2 slave:
// FSM state encoding, bus field widths and cycle-type constants.
package wbm_arb2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_e;

    localparam int ADR_W = 32;
    localparam int DAT_W = 64;
    localparam int SEL_W = 8;
    localparam int CTI_W = 3;
    localparam int BTE_W = 2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // One-hot debug grant seen while sitting in a given state.
    function automatic logic [1:0] state_gnt(input arb_state_e st);
        logic [1:0] gnt;
        case (st)
            ST_GNT0: gnt = 2'b01;
            ST_GNT1: gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/wbm_arb2_if.sv
// One Wishbone B4 link; the master modport drives the request, the slave modport drives the response.
interface wbm_arb2_if;
    import wbm_arb2_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [SEL_W-1:0] sel;
    logic [CTI_W-1:0] cti;
    logic [BTE_W-1:0] bte;
    logic [DAT_W-1:0] dat_r;
    logic             ack;
    logic             err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel, cti, bte,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wbm_arb2_wdog.sv
// Slave-response watchdog: counts strobe cycles that get neither ack nor err and
// flags expiry once the count reaches TIMEOUT.
module wbm_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic wb_clk,
    input  logic rst_i,
    input  logic stb,
    input  logic resp,
    output logic expire
);
    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_r;

    // Unanswered-strobe counter; saturates so it can never wrap back below LIMIT.
    always_ff @(posedge wb_clk or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= 16'd0;
        end else if (!stb || resp) begin
            cnt_r <= 16'd0;
        end else if (cnt_r != 16'hFFFF) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = stb && !resp && (cnt_r == LIMIT);

endmodule

// File: rtl/wbm_arb2.sv
// Two-master Wishbone arbiter for the DDR2 slave: grants a whole cyc to one master,
// round-robin or m0-priority, with a watchdog that aborts a hung slave cycle.
module wbm_arb2
    import wbm_arb2_pkg::*;
#(
    parameter bit M0_PRIO = 1'b0,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk,
    input  logic            rst_i,
    wbm_arb2_if.slave       m0,
    wbm_arb2_if.slave       m1,
    wbm_arb2_if.master      s,
    output logic [1:0]      gnt_o
);
    arb_state_e state_r;
    logic       last_gnt_r;
    logic       abort_idx_r;
    logic [1:0] gnt_r;
    logic       stb_sel_s;
    logic       resp_s;
    logic       expire_s;
    logic       abort_cyc_s;
    logic       m0_wins_s;

    assign stb_sel_s   = (state_r == ST_GNT0) ? m0.stb :
                         (state_r == ST_GNT1) ? m1.stb : 1'b0;
    assign resp_s      = s.ack | s.err;
    assign abort_cyc_s = abort_idx_r ? m1.cyc : m0.cyc;
    // m0 takes a tie when it has priority or m1 held the bus last.
    assign m0_wins_s   = m0.cyc && (!m1.cyc || (M0_PRIO == 1'b1) || last_gnt_r);
    assign gnt_o       = gnt_r;

    wbm_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .wb_clk (wb_clk),
        .rst_i  (rst_i),
        .stb    (stb_sel_s),
        .resp   (resp_s),
        .expire (expire_s)
    );

    // Arbitration FSM with the debug grant registered alongside the state.
    always_ff @(posedge wb_clk or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            last_gnt_r  <= 1'b1;
            abort_idx_r <= 1'b0;
            gnt_r       <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m0_wins_s) begin
                        state_r <= ST_GNT0;
                        gnt_r   <= state_gnt(ST_GNT0);
                    end else if (m1.cyc) begin
                        state_r <= ST_GNT1;
                        gnt_r   <= state_gnt(ST_GNT1);
                    end else begin
                        state_r <= ST_IDLE;
                        gnt_r   <= state_gnt(ST_IDLE);
                    end
                end
                ST_GNT0: begin
                    if (!m0.cyc) begin
                        state_r    <= ST_IDLE;
                        last_gnt_r <= 1'b0;
                        gnt_r      <= state_gnt(ST_IDLE);
                    end else if (expire_s) begin
                        state_r     <= ST_ABORT;
                        abort_idx_r <= 1'b0;
                        gnt_r       <= state_gnt(ST_ABORT);
                    end else begin
                        state_r <= ST_GNT0;
                    end
                end
                ST_GNT1: begin
                    if (!m1.cyc) begin
                        state_r    <= ST_IDLE;
                        last_gnt_r <= 1'b1;
                        gnt_r      <= state_gnt(ST_IDLE);
                    end else if (expire_s) begin
                        state_r     <= ST_ABORT;
                        abort_idx_r <= 1'b1;
                        gnt_r       <= state_gnt(ST_ABORT);
                    end else begin
                        state_r <= ST_GNT1;
                    end
                end
                ST_ABORT: begin
                    if (!abort_cyc_s) begin
                        state_r    <= ST_IDLE;
                        last_gnt_r <= abort_idx_r;
                        gnt_r      <= state_gnt(ST_IDLE);
                    end else begin
                        state_r <= ST_ABORT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 2'b00;
                end
            endcase
        end
    end

    // Bus steering is combinational so a dropped cyc ends the slave cycle in the same clock.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = 32'h0;
        s.dat_w  = 64'h0;
        s.sel    = 8'h0;
        s.cti    = 3'b000;
        s.bte    = 2'b00;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
        case (state_r)
            ST_GNT0: begin
                s.cyc   = m0.cyc;
                s.stb   = m0.stb;
                s.we    = m0.we;
                s.adr   = m0.adr;
                s.dat_w = m0.dat_w;
                s.sel   = m0.sel;
                s.cti   = m0.cti;
                s.bte   = m0.bte;
                m0.ack  = s.ack;
                m0.err  = s.err | expire_s;
            end
            ST_GNT1: begin
                s.cyc   = m1.cyc;
                s.stb   = m1.stb;
                s.we    = m1.we;
                s.adr   = m1.adr;
                s.dat_w = m1.dat_w;
                s.sel   = m1.sel;
                s.cti   = m1.cti;
                s.bte   = m1.bte;
                m1.ack  = s.ack;
                m1.err  = s.err | expire_s;
            end
            default: begin
                s.cyc = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/wbm_arb2.md
WBM_ARB2 -- requirements
Module: wbm_arb2

Interface
REQ-001 M0_PRIO, default 0: 1 = m0 (VGA fetch) has fixed priority; 0 = round-robin.
REQ-002 TIMEOUT, default 255: number of wb_clk cycles with s_stb_o high and no ack/err before an abort; range 1..65535.
REQ-003 wb_clk  in  1  single clock for all logic; everything is sampled on the rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 mN_cyc_i, mN_stb_i, mN_we_i  in  1 each (N=0,1)  Wishbone master request and strobe.
REQ-006 mN_adr_i  in  32  master address.
REQ-007 mN_dat_i  in  64  master write data.
REQ-008 mN_sel_i  in  8  master byte selects.
REQ-009 mN_cti_i  in  3  master cycle type; mN_bte_i  in  2  master burst type.
REQ-010 mN_dat_o  out  64  read data returned to the master.
REQ-011 mN_ack_o, mN_err_o  out  1 each  acknowledge and error to the master.
REQ-012 s_cyc_o, s_stb_o, s_we_o  out  1 each  cycle, strobe and write enable to the DDR2 slave.
REQ-013 s_adr_o  out  32; s_dat_o  out  64; s_sel_o  out  8; s_cti_o  out  3; s_bte_o  out  2  slave request fields.
REQ-014 s_dat_i  in  64; s_ack_i, s_err_i  in  1 each  slave response.
REQ-015 gnt_o  out  2  one-hot grant, for debug.

Function
REQ-016 The arbiter SHALL be a registered FSM with states IDLE, GNT0, GNT1 and ABORT.
REQ-017 IDLE: when any mN_cyc_i is high, the FSM SHALL move to GNTn on the next edge; s_cyc_o SHALL stay 0 while in IDLE.
REQ-018 Simultaneous requests in IDLE:
- M0_PRIO=1: m0 SHALL win.
- M0_PRIO=0: the master not granted last SHALL win; last_gnt resets to 1, so m0 wins first.
REQ-019 GNTn: all s_* request outputs SHALL be the combinational copy of master n's inputs.
REQ-020 GNTn: mn_ack_o = s_ack_i and mn_err_o = s_err_i; the other master's ack/err SHALL be 0.
REQ-021 s_dat_i SHALL be broadcast to both m0_dat_o and m1_dat_o.
REQ-022 The grant SHALL be held for the whole cyc: bursts and cti=3'b111 end-of-burst are never split.
REQ-023 Release: when mn_cyc_i is low in GNTn, the FSM SHALL return to IDLE and update last_gnt=n.
- One dead cycle SHALL separate consecutive grants.
REQ-024 Watchdog counter, 16 bits:
- Clears on every ack/err and whenever s_stb_o is low.
- Increments while s_stb_o is high with no response.
- When it equals TIMEOUT, the FSM SHALL pulse mn_err_o for exactly 1 cycle and enter ABORT.
REQ-025 ABORT: s_cyc_o=s_stb_o=0 and both acks are 0; the FSM SHALL remain in ABORT until the aborted master drops cyc, then go to IDLE.
REQ-026 A stray s_ack_i or s_err_i in IDLE or ABORT SHALL be discarded.
REQ-027 A master that drops cyc mid-burst SHALL end the slave cycle in the same clock, because the outputs are combinational.

Reset
REQ-028 On rst_i low, the following SHALL clear immediately without a clock edge:
- state=IDLE, last_gnt=1, counter=0.
- All s_* outputs, mN_ack_o, mN_err_o and gnt_o = 0.
REQ-029 Reset asserted mid-burst SHALL abort the slave cycle without any err pulse.
- After release, arbitration SHALL restart from IDLE.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=0, GNT0=1, GNT1=2, ABORT=3) and the cti constants CLASSIC=3'b000, INCR=3'b010 and EOB=3'b111.
REQ-031 The watchdog SHALL be one sub-module, wbm_wdog (TIMEOUT parameter; inputs stb, resp; output expire).

Verification
REQ-032 Single request: m1 cyc/stb, adr=32'h3c000, 4 acks -> s_cyc_o rises 1 cycle after m1_cyc_i; m1_ack_o mirrors all 4 acks; m0_ack_o stays 0.
REQ-033 Contention: M0_PRIO=0, both request at the same edge -> grant order m0, m1, m0, with 1 dead cycle between grants.
REQ-034 Priority: M0_PRIO=1, m1 and m0 both pending -> m0 is granted every time.
REQ-035 Burst hold: m0 sends an 8-beat burst (cti 010 x7, then 111) while m1 is waiting -> no grant switch until m0 drops cyc.
REQ-036 Timeout: TIMEOUT=10, slave never acks -> m0_err_o is high for exactly 1 cycle, 10 cycles after stb; s_cyc_o=0 until m0 drops cyc.
REQ-037 Reset on the 3rd beat of a burst -> all outputs are 0 asynchronously; the next request is served normally.
